// File: rtl/bus_master_if.sv
// -----------------------------------------------------------------------------
// bus_master_if
//
// Master-side bus interface. It sits between one bus master (CPU stage, DMA)
// and the bus arbiter, and turns a single-word client read or write into the
// shared-bus handshake:
//   1. Raise the arbitration request.
//   2. Wait for the grant.
//   3. Pulse the address strobe for one cycle.
//   4. Wait for slave ready, capture read data, and release the bus.
// A programmable timeout aborts accesses to slaves that never answer.
//
// Parameters
//   ADDR_W   word-address width
//   DATA_W   data width
//   TIMEOUT  max ACCESS cycles without bm_rdy_ before abort (0 = never abort)
//
// Ports (all outputs are registered)
//   clk, reset    clock; synchronous active-high reset
//   cl_req        client request, only looked at while idle
//   cl_rw         1 = read, 0 = write
//   cl_addr       word address
//   cl_wr_data    write data
//   cl_rd_data    last successfully read word
//   cl_busy       high while an access is in flight
//   cl_done       one-cycle pulse when an access finishes
//   cl_err        one-cycle pulse together with cl_done on timeout
//   bm_req_       bus request to the arbiter (active-low)
//   bm_grnt_      bus grant from the arbiter (active-low)
//   bm_as_        address strobe (active-low)
//   bm_rw         bus direction, 1 = read
//   bm_addr       bus address
//   bm_wr_data    bus write data
//   bm_rd_data    bus read data
//   bm_rdy_       slave ready (active-low)
// -----------------------------------------------------------------------------
module bus_master_if #(
  parameter int ADDR_W  = 30,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 255
) (
  input  logic              clk,
  input  logic              reset,
  // client side
  input  logic              cl_req,
  input  logic              cl_rw,
  input  logic [ADDR_W-1:0] cl_addr,
  input  logic [DATA_W-1:0] cl_wr_data,
  output logic [DATA_W-1:0] cl_rd_data,
  output logic              cl_busy,
  output logic              cl_done,
  output logic              cl_err,
  // bus side
  output logic              bm_req_,
  input  logic              bm_grnt_,
  output logic              bm_as_,
  output logic              bm_rw,
  output logic [ADDR_W-1:0] bm_addr,
  output logic [DATA_W-1:0] bm_wr_data,
  input  logic [DATA_W-1:0] bm_rd_data,
  input  logic              bm_rdy_
);

  // A zero TIMEOUT still needs a 1-bit counter so the declaration stays legal.
  localparam int CNT_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_REQ    = 2'd1,
    S_ACCESS = 2'd2
  } state_t;

  state_t            r_state;
  logic [CNT_W-1:0]  r_cnt;
  logic              r_req_n;
  logic              r_as_n;
  logic              r_rw;
  logic [ADDR_W-1:0] r_addr;
  logic [DATA_W-1:0] r_wr_data;
  logic [DATA_W-1:0] r_rd_data;
  logic              r_busy;
  logic              r_done;
  logic              r_err;

  // The counter holds (ACCESS cycle - 1). The abort is therefore decided in
  // ACCESS cycle TIMEOUT and becomes visible on the following cycle.
  logic w_timeout;
  assign w_timeout = (TIMEOUT != 0) && (r_cnt == CNT_LAST);

  // NOTE: all state updates use non-blocking assignments. Every register then
  // sees the pre-edge values of the others, which matches flop behaviour.
  always_ff @(posedge clk) begin
    // NOTE: the reset is synchronous, so it is sampled like any other input.
    // That is why it does not appear in the sensitivity list.
    if (reset) begin
      r_state   <= S_IDLE;
      r_cnt     <= '0;
      r_req_n   <= 1'b1;
      r_as_n    <= 1'b1;
      r_rw      <= 1'b1;
      r_addr    <= '0;
      r_wr_data <= '0;
      r_rd_data <= '0;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
      r_err     <= 1'b0;
    end else begin
      // completion flags are single-cycle pulses
      r_done <= 1'b0;
      r_err  <= 1'b0;

      case (r_state)
        S_IDLE: begin
          if (cl_req) begin
            // The latched request stays on the bus until the access ends.
            r_rw      <= cl_rw;
            r_addr    <= cl_addr;
            r_wr_data <= cl_wr_data;
            r_req_n   <= 1'b0;
            r_busy    <= 1'b1;
            r_state   <= S_REQ;
          end
        end

        S_REQ: begin
          if (!bm_grnt_) begin
            r_as_n  <= 1'b0;
            r_cnt   <= '0;
            r_state <= S_ACCESS;
          end
        end

        S_ACCESS: begin
          r_as_n <= 1'b1;
          if (!bm_rdy_) begin
            if (r_rw) begin
              r_rd_data <= bm_rd_data;
            end
            r_req_n <= 1'b1;
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
            r_state <= S_IDLE;
          end else if (w_timeout) begin
            r_req_n <= 1'b1;
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
            r_err   <= 1'b1;
            r_state <= S_IDLE;
          end else if (r_cnt != '1) begin
            // Saturate instead of wrapping so a disabled timeout never fires.
            r_cnt <= r_cnt + CNT_ONE;
          end
        end

        default: begin
          r_req_n <= 1'b1;
          r_as_n  <= 1'b1;
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign cl_rd_data = r_rd_data;
  assign cl_busy    = r_busy;
  assign cl_done    = r_done;
  assign cl_err     = r_err;
  assign bm_req_    = r_req_n;
  assign bm_as_     = r_as_n;
  assign bm_rw      = r_rw;
  assign bm_addr    = r_addr;
  assign bm_wr_data = r_wr_data;

endmodule

// File: tb/tb_bus_master_if.sv
// -----------------------------------------------------------------------------
// tb_bus_master_if
//
// Directed bench for bus_master_if, built with TIMEOUT=8. Each scenario
// counts cycles from the cycle in which cl_req is first sampled (c0). The
// grant and ready inputs follow fixed schedules, so every expected value is
// worked out by hand from the documented timing.
// -----------------------------------------------------------------------------
module tb_bus_master_if;

  localparam int ADDR_W = 30;
  localparam int DATA_W = 32;
  localparam int TMO    = 8;

  logic              clk = 1'b0;
  logic              reset;
  logic              cl_req;
  logic              cl_rw;
  logic [ADDR_W-1:0] cl_addr;
  logic [DATA_W-1:0] cl_wr_data;
  logic [DATA_W-1:0] cl_rd_data;
  logic              cl_busy;
  logic              cl_done;
  logic              cl_err;
  logic              bm_req_;
  logic              bm_grnt_;
  logic              bm_as_;
  logic              bm_rw;
  logic [ADDR_W-1:0] bm_addr;
  logic [DATA_W-1:0] bm_wr_data;
  logic [DATA_W-1:0] bm_rd_data;
  logic              bm_rdy_;

  bus_master_if #(
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W),
    .TIMEOUT(TMO)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .cl_req    (cl_req),
    .cl_rw     (cl_rw),
    .cl_addr   (cl_addr),
    .cl_wr_data(cl_wr_data),
    .cl_rd_data(cl_rd_data),
    .cl_busy   (cl_busy),
    .cl_done   (cl_done),
    .cl_err    (cl_err),
    .bm_req_   (bm_req_),
    .bm_grnt_  (bm_grnt_),
    .bm_as_    (bm_as_),
    .bm_rw     (bm_rw),
    .bm_addr   (bm_addr),
    .bm_wr_data(bm_wr_data),
    .bm_rd_data(bm_rd_data),
    .bm_rdy_   (bm_rdy_)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  // per-scenario monitor state
  int                cyc;
  int                n_req_low, n_as_low, n_done, n_err;
  int                done_cyc, err_cyc;
  int                n_unstable;
  logic [ADDR_W-1:0] exp_addr;
  logic [DATA_W-1:0] exp_wr;
  logic              exp_rw;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic clear_mon();
    cyc        = 0;
    n_req_low  = 0;
    n_as_low   = 0;
    n_done     = 0;
    n_err      = 0;
    done_cyc   = -1;
    err_cyc    = -1;
    n_unstable = 0;
  endtask

  // Advance one clock and sample outputs 1 ns after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
    if (!bm_req_) n_req_low++;
    if (!bm_as_)  n_as_low++;
    if (cl_done) begin n_done++; done_cyc = cyc; end
    if (cl_err)  begin n_err++;  err_cyc  = cyc; end
    if (cl_busy && (bm_addr !== exp_addr || bm_wr_data !== exp_wr || bm_rw !== exp_rw))
      n_unstable++;
  endtask

  task automatic issue(input logic rw, input logic [ADDR_W-1:0] addr,
                       input logic [DATA_W-1:0] wd);
    cl_req     = 1'b1;
    cl_rw      = rw;
    cl_addr    = addr;
    cl_wr_data = wd;
    exp_rw     = rw;
    exp_addr   = addr;
    exp_wr     = wd;
  endtask

  task automatic check_reset_vals(input string pfx);
    check({pfx, " bm_req_"},    64'(bm_req_),    64'd1);
    check({pfx, " bm_as_"},     64'(bm_as_),     64'd1);
    check({pfx, " bm_rw"},      64'(bm_rw),      64'd1);
    check({pfx, " bm_addr"},    64'(bm_addr),    64'd0);
    check({pfx, " bm_wr_data"}, 64'(bm_wr_data), 64'd0);
    check({pfx, " cl_rd_data"}, 64'(cl_rd_data), 64'd0);
    check({pfx, " cl_done"},    64'(cl_done),    64'd0);
    check({pfx, " cl_err"},     64'(cl_err),     64'd0);
    check({pfx, " cl_busy"},    64'(cl_busy),    64'd0);
  endtask

  initial begin
    reset      = 1'b1;
    cl_req     = 1'b0;
    cl_rw      = 1'b1;
    cl_addr    = '0;
    cl_wr_data = '0;
    bm_grnt_   = 1'b1;
    bm_rd_data = '0;
    bm_rdy_    = 1'b1;
    exp_addr   = '0;
    exp_wr     = '0;
    exp_rw     = 1'b1;
    clear_mon();
    tick();
    tick();
    check_reset_vals("reset");
    reset = 1'b0;
    tick();

    // ---- 1: read, grant already held, zero-wait slave --------------------
    bm_grnt_   = 1'b0;
    bm_rd_data = 32'hDEADBEEF;
    clear_mon();
    issue(1'b1, 30'h0000100, 32'h0);
    tick();                                   // c1
    cl_req  = 1'b0;
    bm_rdy_ = 1'b0;
    check("rd c1 bm_req_", 64'(bm_req_), 64'd0);
    check("rd c1 busy",    64'(cl_busy), 64'd1);
    check("rd c1 as_",     64'(bm_as_),  64'd1);
    tick();                                   // c2
    check("rd c2 as_",     64'(bm_as_),  64'd0);
    tick();                                   // c3
    check("rd c3 done",    64'(cl_done),    64'd1);
    check("rd c3 err",     64'(cl_err),     64'd0);
    check("rd c3 req_",    64'(bm_req_),    64'd1);
    check("rd c3 rd_data", 64'(cl_rd_data), 64'hDEADBEEF);
    check("rd c3 busy",    64'(cl_busy),    64'd0);
    bm_rdy_ = 1'b1;
    tick();
    check("rd as_ cycles",  64'(n_as_low), 64'd1);
    check("rd done pulses", 64'(n_done),   64'd1);
    check("rd stable",      64'(n_unstable), 64'd0);

    // ---- 2: write, grant low in c4, rdy_ low in ACCESS cycle 3 (c7) ------
    bm_grnt_   = 1'b1;
    bm_rd_data = 32'hBAD0BAD0;
    clear_mon();
    issue(1'b0, 30'h2AAAAAA, 32'h12345678);
    tick();                                   // c1
    cl_req = 1'b0;
    tick(); tick(); tick();                   // c4
    bm_grnt_ = 1'b0;
    tick(); tick(); tick();                   // c7
    bm_rdy_ = 1'b0;
    tick();                                   // c8
    bm_rdy_ = 1'b1;
    tick(); tick();
    check("wr req_ low cycles", 64'(n_req_low),  64'd7);
    check("wr as_ cycles",      64'(n_as_low),   64'd1);
    check("wr done pulses",     64'(n_done),     64'd1);
    check("wr done cycle",      64'(done_cyc),   64'd8);
    check("wr err pulses",      64'(n_err),      64'd0);
    check("wr bus stable",      64'(n_unstable), 64'd0);
    check("wr rd_data kept",    64'(cl_rd_data), 64'hDEADBEEF);

    // ---- 3: timeout, rdy_ never comes; ACCESS1=c2 so ACCESS8=c9 ---------
    clear_mon();
    issue(1'b1, 30'h0000003, 32'h0);
    tick();
    cl_req = 1'b0;
    for (int i = 0; i < 12; i++) tick();
    check("to done cycle",   64'(done_cyc),   64'd10);
    check("to err cycle",    64'(err_cyc),    64'd10);
    check("to done pulses",  64'(n_done),     64'd1);
    check("to err pulses",   64'(n_err),      64'd1);
    check("to req_ low",     64'(n_req_low),  64'd9);
    check("to rd_data kept", 64'(cl_rd_data), 64'hDEADBEEF);

    // ---- 4: back-to-back reads with a zero-wait slave ---------------------
    bm_rdy_    = 1'b0;
    bm_rd_data = 32'hA1A1A1A1;
    clear_mon();
    issue(1'b1, 30'h0000040, 32'h0);
    tick(); tick(); tick();                   // c3: first done, cl_req still high
    check("b2b first done", 64'(cl_done),    64'd1);
    check("b2b gap req_",   64'(bm_req_),    64'd1);
    check("b2b first data", 64'(cl_rd_data), 64'hA1A1A1A1);
    bm_rd_data = 32'hB2B2B2B2;
    tick();                                   // c4
    cl_req = 1'b0;
    check("b2b second req_", 64'(bm_req_), 64'd0);
    tick(); tick();                           // c6
    check("b2b second done", 64'(cl_done),    64'd1);
    check("b2b second data", 64'(cl_rd_data), 64'hB2B2B2B2);
    tick(); tick();
    check("b2b req_ low",    64'(n_req_low), 64'd4);
    check("b2b done pulses", 64'(n_done),    64'd2);
    check("b2b idle busy",   64'(cl_busy),   64'd0);

    // ---- 5: reset while bm_as_ is low ------------------------------------
    bm_rdy_ = 1'b1;
    clear_mon();
    issue(1'b1, 30'h0000077, 32'hCAFEF00D);
    tick(); cl_req = 1'b0;
    tick();                                   // c2, ACCESS
    check("rst as_ low", 64'(bm_as_), 64'd0);
    reset = 1'b1;
    tick();
    check_reset_vals("midrst");
    reset = 1'b0;
    tick(); tick();
    check("rst no done", 64'(n_done), 64'd0);
    bm_rd_data = 32'h55AA55AA;
    bm_rdy_    = 1'b0;
    clear_mon();
    issue(1'b1, 30'h0000078, 32'h0);
    tick(); cl_req = 1'b0;
    tick(); tick();
    check("rst after done", 64'(cl_done),    64'd1);
    check("rst after data", 64'(cl_rd_data), 64'h55AA55AA);

    // ---- 6: client toggles cl_req/cl_addr while busy ----------------------
    bm_rdy_  = 1'b1;
    bm_grnt_ = 1'b1;
    clear_mon();
    issue(1'b1, 30'h0000111, 32'h0);
    tick();                                   // c1
    for (int i = 0; i < 4; i++) begin         // values driven in c1..c4
      cl_req  = ~cl_req;
      cl_addr = 30'h3000000 + 30'(i);
      if (i == 2) bm_grnt_ = 1'b0;            // grant sampled in c3
      tick();
    end
    cl_req  = 1'b0;                           // c5 = ACCESS cycle 2
    bm_rdy_ = 1'b0;
    tick();                                   // c6
    bm_rdy_ = 1'b1;
    for (int i = 0; i < 3; i++) tick();
    check("busy addr stable", 64'(n_unstable), 64'd0);
    check("busy done pulses", 64'(n_done),     64'd1);
    check("busy done cycle",  64'(done_cyc),   64'd6);
    check("busy bm_addr",     64'(bm_addr),    64'h0000111);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
